led_shift_ctrl: RTL and testbench
=================================

// Module: led_shift_ctrl
// PURPOSE
//  Control stage that sits directly upstream of the 8-LED shift register.
//  Debounces two raw pushbuttons: start/stop and direction.
//  Holds run/direction state and divides Clk down to a step rate.
//  Outputs: SS_STEP (one-cycle step enable) and MODE (direction level), wired to the shifter's SS/MODE.
// PARAMETERS
//  DEB_CYCLES  500000    consecutive stable synced samples required to accept a level change
//  TICK_DIV    25000000  base step period in Clk cycles at SPEED=0; must be >= 8
// PORTS
//  Clk       in   1  system clock
//  RST       in   1  asynchronous, active-high reset
//  BTN_SS    in   1  raw start/stop button, asynchronous, active-high, bouncy
//  BTN_MODE  in   1  raw direction button, asynchronous, active-high, bouncy
//  SPEED     in   2  step period select: DIV = TICK_DIV >> SPEED
//  RUN       out  1  1 = shifting enabled (level)
//  MODE      out  1  1 = shift left (LSB->MSB), 0 = shift right
//  SS_STEP   out  1  one-Clk pulse per step, only while RUN=1; drives shifter SS
//  EV_SS     out  1  debug: one-cycle debounced press event, start/stop button
//  EV_MODE   out  1  debug: one-cycle debounced press event, direction button
// BEHAVIOUR
//  Reset (async, immediate): RUN=0, MODE=1, SS_STEP=0, EV_*=0.
//    Also clears synchronizers, debounce counters/FSMs and the divider.
//  Synchronizer: each button passes through 2 flops before any other logic.
//  Debounce FSM, one per button. States: LOW, WAIT_HI, HIGH, WAIT_LO.
//    - LOW: synced=1 -> WAIT_HI, counter cleared.
//    - WAIT_HI: counter increments while synced=1.
//        synced=0 -> back to LOW.
//        counter reaches DEB_CYCLES -> HIGH; EV_x=1 for exactly that cycle.
//    - HIGH: synced=0 -> WAIT_LO, counter cleared.
//    - WAIT_LO: after DEB_CYCLES stable 0 -> LOW; return to HIGH on any 1.
//        No event on release.
//  Press latency: EV_x asserts DEB_CYCLES+2 cycles (+/-1) after the raw rising edge.
//    Raw glitches shorter than DEB_CYCLES never produce an event.
//  Toggles: RUN toggles on the edge after EV_SS; MODE toggles on the edge after EV_MODE.
//    Simultaneous EV_SS and EV_MODE: both toggle in the same cycle.
//  Divider counter: 0..DIV-1, runs only while RUN=1.
//    - Forced to 0 while RUN=0, and on the RUN 0->1 edge.
//    - When RUN=1 and count==DIV-1: SS_STEP=1 for one cycle; count wraps to 0.
//    - First SS_STEP occurs DIV cycles after RUN rises.
//    - Step spacing is exactly DIV cycles.
//  SPEED change mid-count takes effect immediately.
//    If count >= new DIV-1, SS_STEP fires on the next cycle and the count wraps.
//  RUN 1->0: SS_STEP forced 0 on the same edge that clears RUN.
//    No trailing pulse after the stop.
//  MODE toggle coinciding with SS_STEP: shifter sees the updated MODE with that step.
//    MODE and SS_STEP are both registered on the same edge.
//  RST asserted mid-debounce or mid-count: all state is lost.
//    A button still held at release of RST must complete a full debounce before an event.
// TESTING  (bench overrides DEB_CYCLES=4, TICK_DIV=16)
//  1. Assert RST, release -> RUN=0, MODE=1, SS_STEP=0.
//     No EV_* pulses with buttons idle for 100 cycles.
//  2. BTN_SS pulses of 1-3 cycles, repeated -> no EV_SS, RUN stays 0.
//     Hold 10 cycles -> exactly one EV_SS, RUN=1; release -> no event.
//  3. RUN=1, SPEED=0 -> SS_STEP 1 cycle wide every 16 cycles, first at 16 after RUN rises.
//     SPEED=2 -> period becomes 4.
//  4. Press BTN_MODE while running -> MODE toggles once, steps continue unbroken.
//     Press BTN_SS and BTN_MODE together -> RUN and MODE both toggle in the same cycle.
//  5. Second BTN_SS press -> RUN=0, no further SS_STEP.
//     Re-press -> first SS_STEP exactly 16 cycles after RUN=1.
//  6. Assert RST while running and while BTN_SS is in WAIT_HI -> outputs reset at once.
//     Held button needs a full 4-cycle debounce after RST release before EV_SS.

Source files
------------

// File: rtl/led_shift_ctrl.sv
// -----------------------------------------------------------------------------
// led_shift_ctrl
//   Control stage for the 8-LED shift register. Debounces the start/stop and
//   direction pushbuttons, holds the run/direction state and divides Clk down
//   to the step rate that drives the shifter's SS input.
//
//   Ports
//     Clk       in   system clock
//     RST       in   asynchronous, active-high reset
//     BTN_SS    in   raw start/stop button (async, bouncy)
//     BTN_MODE  in   raw direction button (async, bouncy)
//     SPEED     in   step period select, period = TICK_DIV >> SPEED
//     RUN       out  1 = shifting enabled
//     MODE      out  1 = shift left, 0 = shift right
//     SS_STEP   out  one-cycle step enable, only while RUN=1
//     EV_SS     out  debounced press event, start/stop button
//     EV_MODE   out  debounced press event, direction button
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// led_shift_debounce
//   Two-flop synchronizer followed by a press/release debounce FSM.
//   A level change is accepted only after DEB_CYCLES consecutive stable
//   synchronized samples; a one-cycle event is produced on accepted presses.
//
//   Ports
//     Clk   in   system clock
//     RST   in   asynchronous, active-high reset
//     raw   in   raw asynchronous button level
//     ev    out  one-cycle registered press event
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_LOW      | button accepted as released
//   S_WAIT_HI  | synced level went high, counting stable high samples
//   S_HIGH     | button accepted as pressed
//   S_WAIT_LO  | synced level went low, counting stable low samples
// -----------------------------------------------------------------------------
module led_shift_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic Clk,
  input  logic RST,
  input  logic raw,
  output logic ev
);

  localparam int DCW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HI,
    S_HIGH,
    S_WAIT_LO
  } state_t;

  state_t         state;
  logic [1:0]     sync;
  logic [DCW-1:0] cnt;
  logic           synced;

  assign synced = sync[1];

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      sync  <= 2'b00;
      state <= S_LOW;
      cnt   <= '0;
      ev    <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      ev   <= 1'b0;
      case (state)
        S_LOW: begin
          cnt <= '0;
          if (synced) state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (!synced) begin
            state <= S_LOW;
          end else if (cnt == DEB_LAST) begin
            // The event is registered together with the state change so it
            // is exactly one cycle wide.
            state <= S_HIGH;
            ev    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          cnt <= '0;
          if (!synced) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          // Release is debounced too, but produces no event.
          if (synced) begin
            state <= S_HIGH;
          end else if (cnt == DEB_LAST) begin
            state <= S_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// -----------------------------------------------------------------------------
// led_shift_ctrl top
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   RUN=0 | stopped: divider held at 0, no steps
//   RUN=1 | running: divider counts 0..DIV-1, SS_STEP pulses on each wrap
// -----------------------------------------------------------------------------
module led_shift_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 25000000
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       BTN_SS,
  input  logic       BTN_MODE,
  input  logic [1:0] SPEED,
  output logic       RUN,
  output logic       MODE,
  output logic       SS_STEP,
  output logic       EV_SS,
  output logic       EV_MODE
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam logic [CW-1:0] TICK_DIV_W = CW'(TICK_DIV);

  logic [CW-1:0] div_cnt;
  logic [CW-1:0] div_len;
  logic [CW-1:0] div_last;
  logic          ev_ss;
  logic          ev_mode;

  led_shift_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_ss (
    .Clk(Clk),
    .RST(RST),
    .raw(BTN_SS),
    .ev (ev_ss)
  );

  led_shift_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb_mode (
    .Clk(Clk),
    .RST(RST),
    .raw(BTN_MODE),
    .ev (ev_mode)
  );

  assign EV_SS   = ev_ss;
  assign EV_MODE = ev_mode;

  // Period follows SPEED combinationally, so a change applies on the very
  // next edge. TICK_DIV >= 8 keeps div_len >= 1 for every SPEED value.
  assign div_len  = TICK_DIV_W >> SPEED;
  assign div_last = div_len - CW'(1);

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      RUN     <= 1'b0;
      MODE    <= 1'b1;
      SS_STEP <= 1'b0;
      div_cnt <= '0;
    end else begin
      SS_STEP <= 1'b0;
      // MODE and SS_STEP share this edge, so a step issued together with a
      // toggle already carries the new direction.
      MODE    <= MODE ^ ev_mode;
      if (ev_ss) begin
        // Starting restarts the period from 0; stopping suppresses any step
        // that would have fired on this edge.
        RUN     <= ~RUN;
        div_cnt <= '0;
      end else if (!RUN) begin
        div_cnt <= '0;
      end else if (div_cnt >= div_last) begin
        // ">=" handles a SPEED change that shrinks the period below the
        // current count: step immediately and wrap.
        SS_STEP <= 1'b1;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_shift_ctrl.sv
module tb_led_shift_ctrl;

  localparam int DEB = 4;
  localparam int TDIV = 16;
  localparam int EV_LAT = DEB + 3;   // raw drive -> EV sample
  localparam int K_EV_SS = 0, K_EV_MODE = 1, K_STEP = 2, K_RUN = 3, K_MODE = 4;

  logic       Clk;
  logic       RST;
  logic       BTN_SS;
  logic       BTN_MODE;
  logic [1:0] SPEED;
  logic       RUN, MODE, SS_STEP, EV_SS, EV_MODE;

  led_shift_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .Clk(Clk), .RST(RST), .BTN_SS(BTN_SS), .BTN_MODE(BTN_MODE), .SPEED(SPEED),
    .RUN(RUN), .MODE(MODE), .SS_STEP(SS_STEP), .EV_SS(EV_SS), .EV_MODE(EV_MODE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;
    bit val;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 0;

  // expected step schedule
  bit exp_run   = 0;
  bit exp_mode  = 1;
  bit sched_on  = 0;
  int next_step = 0;
  int stop_at   = 0;
  int cur_div   = TDIV;

  function automatic string kname(int k);
    case (k)
      K_EV_SS:   return "EV_SS";
      K_EV_MODE: return "EV_MODE";
      K_STEP:    return "SS_STEP";
      K_RUN:     return "RUN";
      default:   return "MODE";
    endcase
  endfunction

  function automatic void push_exp(int c, int k, bit v);
    exp_t e;
    int i = 0;
    e.cyc = c; e.kind = k; e.val = v;
    while (i < q.size() && (q[i].cyc < c || (q[i].cyc == c && q[i].kind <= k))) i++;
    q.insert(i, e);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  // Called at a negedge: queue the step expected at the next sample.
  function automatic void sched_push();
    if (sched_on && next_step == cyc + 1) begin
      if (cyc + 1 < stop_at) push_exp(cyc + 1, K_STEP, 1'b1);
      next_step += cur_div;
    end
    if (sched_on && cyc + 1 >= stop_at) sched_on = 0;
  endfunction

  task automatic tick();
    @(negedge Clk);
    sched_push();
  endtask

  // Expectations for a qualifying press whose raw edge is driven now.
  function automatic void expect_press(bit ss, bit md);
    int p = cyc;
    if (ss) begin
      push_exp(p + EV_LAT, K_EV_SS, 1'b1);
      if (!exp_run) begin
        exp_run   = 1;
        sched_on  = 1;
        next_step = p + EV_LAT + 1 + cur_div;
        stop_at   = 32'h7fff_ffff;
      end else begin
        exp_run = 0;
        stop_at = p + EV_LAT + 1;
      end
      push_exp(p + EV_LAT + 1, K_RUN, exp_run);
    end
    if (md) begin
      push_exp(p + EV_LAT, K_EV_MODE, 1'b1);
      exp_mode = ~exp_mode;
      push_exp(p + EV_LAT + 1, K_MODE, exp_mode);
    end
  endfunction

  task automatic press(bit ss, bit md, int hold);
    tick();
    BTN_SS   = ss;
    BTN_MODE = md;
    expect_press(ss, md);
    repeat (hold) tick();
    BTN_SS   = 1'b0;
    BTN_MODE = 1'b0;
  endtask

  task automatic glitch(bit ss, int w);
    tick();
    if (ss) BTN_SS = 1'b1; else BTN_MODE = 1'b1;
    repeat (w) tick();
    BTN_SS   = 1'b0;
    BTN_MODE = 1'b0;
  endtask

  task automatic set_speed(logic [1:0] s);
    int base, nd, nxt;
    @(negedge Clk);
    SPEED = s;
    nd = TDIV >> s;
    if (sched_on) begin
      base = next_step - cur_div;
      nxt  = base + nd;
      next_step = (nxt < cyc + 1) ? cyc + 1 : nxt;
    end
    cur_div = nd;
    sched_push();
  endtask

  // Monitor: every pulse or level change the DUT shows must match the
  // head of the expectation queue.
  initial begin
    bit prev_run  = 0;
    bit prev_mode = 1;
    bit obs[5];
    bit val[5];
    forever begin
      @(posedge Clk);
      #1;
      if (mon_en) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          n_total++;
          $display("FAIL missing %s: got none expected %0d at cyc %0d", kname(q[0].kind), q[0].val, q[0].cyc);
          void'(q.pop_front());
        end
        obs[K_EV_SS]   = EV_SS;      val[K_EV_SS]   = 1'b1;
        obs[K_EV_MODE] = EV_MODE;    val[K_EV_MODE] = 1'b1;
        obs[K_STEP]    = SS_STEP;    val[K_STEP]    = 1'b1;
        obs[K_RUN]     = (RUN  !== prev_run);  val[K_RUN]  = RUN;
        obs[K_MODE]    = (MODE !== prev_mode); val[K_MODE] = MODE;
        for (int k = 0; k < 5; k++) begin
          if (obs[k]) begin
            n_total++;
            if (q.size() > 0 && q[0].cyc == cyc && q[0].kind == k) begin
              if (q[0].val == val[k]) n_pass++;
              else $display("FAIL %s value at cyc %0d: got %0d expected %0d", kname(k), cyc, val[k], q[0].val);
              void'(q.pop_front());
            end else begin
              $display("FAIL unexpected %s at cyc %0d: got %0d expected none", kname(k), cyc, val[k]);
            end
          end
        end
      end
      prev_run  = RUN;
      prev_mode = MODE;
    end
  end

  initial begin
    RST = 1'b1; BTN_SS = 1'b0; BTN_MODE = 1'b0; SPEED = 2'd0;
    repeat (3) @(negedge Clk);
    chk("reset RUN", RUN, 0);
    chk("reset MODE", MODE, 1);
    chk("reset SS_STEP", SS_STEP, 0);
    chk("reset EV_SS", EV_SS, 0);
    chk("reset EV_MODE", EV_MODE, 0);
    @(negedge Clk);
    RST = 1'b0;
    mon_en = 1;
    repeat (100) tick();
    chk("idle RUN", RUN, 0);

    // short bounces never qualify
    for (int r = 0; r < 2; r++)
      for (int w = 1; w <= 3; w++) begin
        glitch(1'b1, w);
        repeat (8) tick();
      end
    glitch(1'b0, DEB);
    repeat (10) tick();
    chk("glitch RUN", RUN, 0);
    chk("glitch MODE", MODE, 1);

    // start, steps at period 16
    press(1'b1, 1'b0, 10);
    repeat (15) tick();
    chk("started RUN", RUN, 1);
    repeat (40) tick();

    // shrink period to 4 mid-count
    set_speed(2'd2);
    repeat (20) tick();

    // direction toggle while running
    press(1'b0, 1'b1, 10);
    repeat (20) tick();

    // both buttons together: stop + toggle same cycle
    press(1'b1, 1'b1, 10);
    repeat (30) tick();
    chk("stopped RUN", RUN, 0);

    // restart at period 16
    set_speed(2'd0);
    repeat (5) tick();
    press(1'b1, 1'b0, 10);
    repeat (50) tick();
    set_speed(2'd1);
    repeat (20) tick();

    // reset while running with BTN_SS mid-debounce
    tick();
    BTN_SS = 1'b1;
    repeat (4) tick();
    @(negedge Clk);
    RST = 1'b1;
    mon_en = 0;
    q.delete();
    sched_on = 0;
    exp_run  = 0;
    exp_mode = 1;
    #1;
    chk("async RST RUN", RUN, 0);
    chk("async RST MODE", MODE, 1);
    chk("async RST SS_STEP", SS_STEP, 0);
    repeat (3) @(negedge Clk);
    RST = 1'b0;
    expect_press(1'b1, 1'b0);
    mon_en = 1;
    repeat (10) tick();
    BTN_SS = 1'b0;
    repeat (40) tick();

    press(1'b1, 1'b0, 10);
    repeat (30) tick();
    chk("final RUN", RUN, 0);
    chk("queue drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
